// File: rtl/rr_fifo_arbiter.sv
// Round-robin pop scheduler for four input FIFOs sharing one 10-bit output path.
// The mux select and downstream push are registered so they line up with the FIFO read data.
module rr_fifo_arbiter #(
  parameter int unsigned QUANTUM = 1,
  parameter int unsigned CNT_W   = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:0] fifo_empty_i,
  input  logic       out_almost_full_i,
  output logic [3:0] pop_o,
  output logic [1:0] select_o,
  output logic       push_out_o,
  output logic       grant_active_o
);

  localparam logic [CNT_W-1:0] QuantumCnt = CNT_W'(QUANTUM);
  localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);

  typedef enum logic [0:0] {StIdle, StServe} state_e;

  state_e           state_q, state_d;
  logic [1:0]       cur_q, cur_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       select_q;
  logic             push_q;
  logic             grant_q;

  logic [3:0] req;
  logic       can_go;
  logic       any_req;
  logic       found;
  logic [1:0] cand;
  logic [1:0] srch_idx;
  logic       pop_en;
  logic [1:0] pop_idx;

  assign req     = ~fifo_empty_i;
  assign can_go  = ~out_almost_full_i;
  assign any_req = |req;

  // Scan cur+1, cur+2, cur+3 and finally cur itself, so cur wins only as sole requester.
  always_comb begin
    found    = 1'b0;
    srch_idx = cur_q;
    cand     = cur_q;
    for (int unsigned k = 1; k <= 4; k++) begin
      cand = cur_q + 2'(k);
      if (!found && req[cand]) begin
        found    = 1'b1;
        srch_idx = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    pop_en  = 1'b0;
    pop_idx = cur_q;
    case (state_q)
      StIdle: begin
        if (can_go && found) begin
          pop_en  = 1'b1;
          pop_idx = srch_idx;
          cur_d   = srch_idx;
          cnt_d   = CntOne;
          state_d = StServe;
        end
      end
      StServe: begin
        // A stall leaves cur/cnt untouched so the burst resumes where it stopped.
        if (can_go) begin
          if (req[cur_q] && (cnt_q < QuantumCnt)) begin
            pop_en  = 1'b1;
            pop_idx = cur_q;
            cnt_d   = cnt_q + CntOne;
          end else if (found) begin
            pop_en  = 1'b1;
            pop_idx = srch_idx;
            cur_d   = srch_idx;
            cnt_d   = CntOne;
          end else begin
            state_d = StIdle;
            cnt_d   = '0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Gate with reset so no strobe reaches the FIFOs while reset is held.
  assign pop_o = (pop_en && rst_ni) ? (4'b0001 << pop_idx) : 4'b0000;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      cur_q    <= 2'd3;
      cnt_q    <= '0;
      select_q <= 2'd0;
      push_q   <= 1'b0;
      grant_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      push_q  <= pop_en;
      grant_q <= (state_d == StServe);
      if (pop_en) begin
        select_q <= pop_idx;
      end
    end
  end

  assign select_o       = select_q;
  assign push_out_o     = push_q;
  assign grant_active_o = grant_q;

endmodule
